// File: rtl/string_codec_pkg.sv
// Shared constants for the symbol-code <-> ASCII string path.
// Code and ASCII values used by the assembler and its code-to-ASCII mapper.
package string_codec_pkg;

   localparam int CODE_SPACE = 'h00;
   localparam int CODE_A     = 'h01;
   localparam int CODE_Z     = 'h1A;
   localparam int CODE_LA    = 'h1B;
   localparam int CODE_LZ    = 'h34;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_LA    = 8'h61;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_t;

endpackage

// File: rtl/code_to_ascii.sv
// Combinational symbol-code to ASCII mapper.
// Optional macro STRING_ASSEMBLER_LOWERCASE_EN enables codes 0x1B..0x34 as 'a'..'z';
// without it those codes are treated as invalid.
module code_to_ascii
   import string_codec_pkg::*;
#(
   parameter int CODE_W = 8
) (
   input  logic [CODE_W-1:0] code,
   output logic [7:0]        ascii,
   output logic              invalid
);

   int code_val;

   // Anything outside the known ranges becomes '?' and is flagged invalid.
   always_comb begin
      code_val = int'(code);
      ascii    = ASCII_QMARK;
      invalid  = 1'b1;
      if (code_val == CODE_SPACE) begin
         ascii   = ASCII_SPACE;
         invalid = 1'b0;
      end else if (code_val >= CODE_A && code_val <= CODE_Z) begin
         ascii   = ASCII_A + 8'(code_val - CODE_A);
         invalid = 1'b0;
      end
`ifdef STRING_ASSEMBLER_LOWERCASE_EN
      else if (code_val >= CODE_LA && code_val <= CODE_LZ) begin
         ascii   = ASCII_LA + 8'(code_val - CODE_LA);
         invalid = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/string_assembler.sv
// Collects per-character symbol codes into a packed ASCII string.
// Character i lands in str_out[8*i+7:8*i]; short strings are space padded.
// Lowercase support is selected by STRING_ASSEMBLER_LOWERCASE_EN (see code_to_ascii).
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   COLLECT | accepting codes, writing mapped chars at idx
//   EMIT    | str_out/str_err presented, waiting for str_ready
module string_assembler
   import string_codec_pkg::*;
#(
   parameter int STRING_LENGTH = 4,
   parameter int CODE_W        = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [CODE_W-1:0]          code_in,
   input  logic                       code_valid,
   input  logic                       code_last,
   output logic                       code_ready,
   output logic [8*STRING_LENGTH-1:0] str_out,
   output logic                       str_valid,
   input  logic                       str_ready,
   output logic                       str_err
);

   localparam int IDX_W = (STRING_LENGTH > 1) ? $clog2(STRING_LENGTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STRING_LENGTH - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             err;
   logic [7:0]       ch;
   logic             ch_bad;
   logic             accept;
   logic             final_char;

   code_to_ascii #(.CODE_W(CODE_W)) u_map (
      .code    (code_in),
      .ascii   (ch),
      .invalid (ch_bad)
   );

   // Ready is gated by rst_n so it stays low while reset is held.
   assign code_ready = rst_n && (state == COLLECT);
   assign str_valid  = (state == EMIT);
   assign str_err    = err && str_valid;
   assign accept     = code_valid && code_ready;
   assign final_char = code_last || (idx == LAST_IDX);

   // Collect characters, pad on the final one, then hold the string until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= COLLECT;
         idx     <= '0;
         err     <= 1'b0;
         str_out <= {STRING_LENGTH{ASCII_SPACE}};
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  for (int i = 0; i < STRING_LENGTH; i++) begin
                     if (i == int'(idx))
                        str_out[8*i +: 8] <= ch;
                     else if (final_char && i > int'(idx))
                        str_out[8*i +: 8] <= ASCII_SPACE;
                  end
                  err <= err | ch_bad;
                  if (final_char)
                     state <= EMIT;
                  else
                     idx <= idx + 1'b1;
               end
            end
            EMIT: begin
               if (str_ready) begin
                  state <= COLLECT;
                  idx   <= '0;
                  err   <= 1'b0;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_string_assembler.sv
// Scoreboard bench for string_assembler: expected strings are pushed when a
// string is issued; a monitor pops and compares on each output handshake.
module tb_string_assembler;

   localparam int N  = 4;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [CW-1:0]   code_in = '0;
   logic            code_valid = 1'b0;
   logic            code_last = 1'b0;
   logic            code_ready;
   logic [8*N-1:0]  str_out;
   logic            str_valid;
   logic            str_ready = 1'b0;
   logic            str_err;

   int checks = 0;
   int failures = 0;
   int rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
   bit rand_gaps = 1'b0;

   logic [8*N-1:0] exp_str_q[$];
   logic           exp_err_q[$];

   always #5 clk = ~clk;

   string_assembler #(.STRING_LENGTH(N), .CODE_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .code_last  (code_last),
      .code_ready (code_ready),
      .str_out    (str_out),
      .str_valid  (str_valid),
      .str_ready  (str_ready),
      .str_err    (str_err)
   );

   // Reference mapping: {invalid, ascii}
   function automatic logic [8:0] ref_map(input int c);
      if (c == 0) return {1'b0, 8'h20};
      if (c >= 1 && c <= 26) return {1'b0, 8'(65 + c - 1)};
`ifdef STRING_ASSEMBLER_LOWERCASE_EN
      if (c >= 27 && c <= 52) return {1'b0, 8'(97 + c - 27)};
`endif
      return {1'b1, 8'h3F};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic expect_string(input int codes[$]);
      logic [8*N-1:0] s;
      logic           e;
      logic [8:0]     m;
      s = {N{8'h20}};
      e = 1'b0;
      foreach (codes[k]) begin
         m = ref_map(codes[k]);
         s[8*k +: 8] = m[7:0];
         e = e | m[8];
      end
      exp_str_q.push_back(s);
      exp_err_q.push_back(e);
   endtask

   task automatic send_code(input int c, input logic last);
      bit done;
      done = 1'b0;
      code_in    = CW'(c);
      code_last  = last;
      code_valid = 1'b1;
      for (int w = 0; w < 300 && !done; w++) begin
         @(negedge clk);
         done = code_ready;
         @(posedge clk);
         #1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted code=%h", c);
      end
      code_valid = 1'b0;
      code_last  = 1'b0;
   endtask

   task automatic send_string(input int codes[$], input bit last_on_end, input bit push);
      if (push) expect_string(codes);
      foreach (codes[k]) begin
         if (rand_gaps) begin
            repeat ($urandom_range(0, 2)) begin
               code_valid = 1'b0;
               code_last  = 1'($urandom_range(0, 1));
               code_in    = CW'($urandom_range(0, 255));
               @(posedge clk);
               #1;
            end
         end
         send_code(codes[k], (k == codes.size() - 1) ? last_on_end : 1'b0);
      end
   endtask

   task automatic drain();
      for (int w = 0; w < 200 && exp_str_q.size() != 0; w++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (exp_str_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0", exp_str_q.size());
      end
   endtask

   task automatic check_reset_values();
      check("rst_str_valid", 64'(str_valid), 64'(0));
      check("rst_code_ready", 64'(code_ready), 64'(0));
      check("rst_str_err", 64'(str_err), 64'(0));
      check("rst_str_out", 64'(str_out), 64'({N{8'h20}}));
   endtask

   task automatic ready_driver();
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0: str_ready = 1'b1;
            1: str_ready = 1'($urandom_range(0, 1));
            default: str_ready = 1'b0;
         endcase
      end
   endtask

   task automatic monitor();
      logic [8*N-1:0] held;
      bit hold_active;
      bit expect_valid;
      int acc;
      hold_active = 1'b0;
      expect_valid = 1'b0;
      acc = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_active = 1'b0;
            expect_valid = 1'b0;
            acc = 0;
            continue;
         end
         if (expect_valid) check("latency_str_valid", 64'(str_valid), 64'(1));
         expect_valid = 1'b0;
         check("code_ready_vs_valid", 64'(code_ready), 64'(!str_valid));
         if (hold_active && str_valid) check("str_out_stable", 64'(str_out), 64'(held));
         if (str_valid && str_ready) begin
            checks++;
            if (exp_str_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_string actual=%h required=none", str_out);
            end else begin
               check("str_out", 64'(str_out), 64'(exp_str_q.pop_front()));
               check("str_err", 64'(str_err), 64'(exp_err_q.pop_front()));
            end
            hold_active = 1'b0;
         end else if (str_valid) begin
            hold_active = 1'b1;
            held = str_out;
         end else begin
            hold_active = 1'b0;
         end
         if (code_valid && code_ready) begin
            if (code_last || acc == N - 1) begin
               expect_valid = 1'b1;
               acc = 0;
            end else begin
               acc++;
            end
         end
      end
   endtask

   initial begin
      int q[$];
      int len;
      int r;
      bit lst;

      fork
         monitor();
         ready_driver();
      join_none

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values();
      @(posedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 0;

      // Full string, short string, string with an invalid code, then a clean one
      send_string('{1, 2, 3, 4}, 1'b1, 1'b1);
      send_string('{8, 9}, 1'b1, 1'b1);
      send_string('{1, 'h40, 2, 3}, 1'b0, 1'b1);
      send_string('{1, 2, 3, 4}, 1'b1, 1'b1);
      drain();

      // Output back-pressure with a code held valid during EMIT
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send_string('{1, 2, 3, 4}, 1'b0, 1'b1);
      code_valid = 1'b1;
      code_in    = CW'('h1A);
      code_last  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("hold_str_valid", 64'(str_valid), 64'(1));
         check("hold_code_ready", 64'(code_ready), 64'(0));
         @(posedge clk);
         #1;
      end
      expect_string('{'h1A, 1});
      rdy_mode = 0;
      send_code('h1A, 1'b0);
      send_code(1, 1'b1);
      drain();

      // First lowercase code: valid only with the lowercase macro
      send_string('{'h1B}, 1'b1, 1'b1);
      drain();

      // Reset mid-string discards the partial string
      send_code(3, 1'b0);
      send_code(4, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_values();
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_string('{5}, 1'b1, 1'b1);
      drain();

      // Randomized strings with random gaps and random output back-pressure
      rdy_mode  = 1;
      rand_gaps = 1'b1;
      for (int s = 0; s < 80; s++) begin
         q.delete();
         len = $urandom_range(1, N);
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      q.push_back($urandom_range(0, 26));
            else if (r < 9) q.push_back($urandom_range(27, 52));
            else            q.push_back($urandom_range(53, 255));
         end
         lst = (len < N) ? 1'b1 : 1'($urandom_range(0, 1));
         send_string(q, lst, 1'b1);
      end
      rdy_mode = 0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
